// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - multi-cycle ALU with iterative SLL; define ALU_OVERFLOW_EN to enable the signed overflow flag
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             overflow
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // second operand; doubles as the SLL working value
  logic [3:0]       op_q, op_d;
  logic [4:0]       cnt_q, cnt_d;   // remaining single-bit SLL shifts
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_legal;
  logic [WIDTH-1:0] shl_val;

`ifdef ALU_OVERFLOW_EN
  logic             overflow_q, overflow_d;
  logic             alu_ovf;
`endif

  // Single-cycle datapath evaluated on the latched operands
  always_comb begin
    sum       = a_q + b_q;
    diff      = a_q - b_q;
    alu_res   = '0;
    alu_legal = 1'b1;
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      default: begin
        alu_res   = '0;
        alu_legal = 1'b0;
      end
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: operand signs dictate whether the result sign may flip
  always_comb begin
    alu_ovf = 1'b0;
    if (op_q == OP_ADD)
      alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    else if (op_q == OP_SUB)
      alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
  end
`endif

  // Next-state and datapath control for the IDLE/BUSY/DONE sequence
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    shl_val   = b_q << 1;
`ifdef ALU_OVERFLOW_EN
    overflow_d = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = ALUctr;
          cnt_d   = shamt;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (op_q == OP_SLL) begin
          if (cnt_q > 5'd1) begin
            b_d   = shl_val;
            cnt_d = cnt_q - 5'd1;
          end else begin
            // Last (or, for shamt=0, no) shift lands directly in the result
            result_d  = (cnt_q == 5'd1) ? shl_val : b_q;
            b_d       = result_d;
            cnt_d     = 5'd0;
            zero_d    = (result_d == '0);
            illegal_d = 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow_d = 1'b0;
`endif
            state_d   = DONE;
          end
        end else begin
          result_d  = alu_res;
          zero_d    = (alu_res == '0);
          illegal_d = ~alu_legal;
`ifdef ALU_OVERFLOW_EN
          overflow_d = alu_ovf;
`endif
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 4'b0000;
      cnt_q     <= 5'd0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  // Overflow flag register, present only when the feature is enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - scoreboard testbench for alu_iterative (honours ALU_OVERFLOW_EN)
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ALUctr = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic        busy, done, zero, illegal, overflow;
  logic [31:0] result;

  alu_iterative #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUctr(ALUctr),
    .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
    .result(result), .zero(zero), .illegal(illegal), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    bit          z;
    bit          il;
    bit          ov;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain arithmetic on the opcode meaning
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] aa,
                                 input logic [31:0] bb, input logic [4:0] sh);
    exp_t   e;
    longint sa, sb, s;
    longint hi = 64'sh7FFFFFFF;
    longint lo = -64'sh80000000;
    sa = $signed(aa);
    sb = $signed(bb);
    e.r = 32'd0; e.il = 0; e.ov = 0; e.lat = 1; e.acc = 0;
    case (op)
      4'b0000: e.r = aa & bb;
      4'b0001: e.r = aa | bb;
      4'b0010: begin e.r = aa + bb; s = sa + sb; e.ov = (s > hi) || (s < lo); end
      4'b0110: begin e.r = aa - bb; s = sa - sb; e.ov = (s > hi) || (s < lo); end
      4'b0111: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0101: e.r = (aa < bb) ? 32'd1 : 32'd0;
      4'b1000: begin e.r = bb << sh; e.lat = (sh == 0) ? 1 : int'(sh); end
      default: begin e.r = 32'd0; e.il = 1; end
    endcase
    e.z = (e.r == 32'd0);
`ifndef ALU_OVERFLOW_EN
    e.ov = 0;
`endif
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", result, mon_e.r);
        chk("zero", {31'd0, zero}, {31'd0, mon_e.z});
        chk("illegal", {31'd0, illegal}, {31'd0, mon_e.il});
        chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ov});
        chk("latency", cyc - mon_e.acc, mon_e.lat);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] sh, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    ALUctr = op; a = aa; b = bb; shamt = sh; start = 1'b1;
    if (push) begin
      e = model(op, aa, bb, sh);
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; shamt = 5'($urandom); ALUctr = 4'($urandom);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 80) begin @(negedge clk); #1; n++; end
    chk(name, sbq.size(), 0);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [4:0] sh, input string name);
    issue(op, aa, bb, sh, 1);
    drain(name);
  endtask

  logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b1000, 4'b0011};

  initial begin
    int dc;
    int n;
    exp_t e;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(4'b0010, 32'h5, 32'h3, 5'd0, "drain_add");
    run(4'b0110, 32'd3, 32'd3, 5'd0, "drain_sub");
    run(4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, "drain_slt");
    run(4'b0101, 32'hFFFFFFFF, 32'd1, 5'd0, "drain_sltu");
    run(4'b1000, 32'h0, 32'h1, 5'd31, "drain_sll31");
    run(4'b1000, 32'h0, 32'h1, 5'd0, "drain_sll0");
    run(4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, "drain_add_ovf");
    run(4'b0110, 32'h80000000, 32'd1, 5'd0, "drain_sub_ovf");
    run(4'b1111, 32'h12345678, 32'h9, 5'd3, "drain_illegal");
    run(4'b0001, 32'hA0, 32'h05, 5'd0, "drain_or_clears_illegal");

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = ops[$urandom_range(0, 7)];
      if (op == 4'b0011) op = 4'($urandom);
      run(op, $urandom, $urandom, 5'($urandom), "drain_random");
    end

    // start held high through an SLL: exactly one completion
    dc = done_cnt;
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    ALUctr = 4'b1000; a = 32'd0; b = 32'h1; shamt = 5'd10; start = 1'b1;
    e = model(4'b1000, 32'd0, 32'h1, 5'd10);
    e.acc = cyc + 1;
    sbq.push_back(e);
    n = 0;
    while (n < 60) begin
      @(negedge clk); #1;
      if (done) break;
      a = $urandom; b = $urandom; shamt = 5'($urandom); ALUctr = 4'($urandom);
      n++;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_start_completions", done_cnt - dc, 1);
    chk("hold_start_idle", {31'd0, busy}, 32'd0);
    chk("hold_start_queue", sbq.size(), 0);

    // reset in the middle of a long shift
    issue(4'b1000, 32'd0, 32'h3, 5'd20, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    dc = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_done", done_cnt - dc, 0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);

    run(4'b0010, 32'h10, 32'h20, 5'd0, "drain_after_reset");
    run(4'b0000, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0, "drain_and_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_iterative.md
ALU_ITERATIVE -- requirements
Module: alu_iterative

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, the operand and result width; only 32 is supported.
REQ-002 The block SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL provide port start, input, 1, a request to begin an operation.
REQ-005 The block SHALL provide port ALUctr, input, 4, the operation code from the ALU control unit.
REQ-006 The block SHALL provide ports a and b, input, WIDTH each, the operands.
REQ-007 The block SHALL provide port shamt, input, 5, the SLL shift amount.
REQ-008 The block SHALL provide port busy, output, 1, high whenever state is not IDLE.
REQ-009 The block SHALL provide port done, output, 1, a one-cycle pulse marking result valid.
REQ-010 The block SHALL provide port result, output, WIDTH, the registered result.
REQ-011 The block SHALL provide ports zero, illegal and overflow, output, 1 each: result==0, unsupported ALUctr, and signed overflow.

Function
REQ-012 The opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 SLT (signed, result 1/0), 0101 SLTU (unsigned, result 1/0), 1000 SLL (b shifted left by shamt).
REQ-013 Arithmetic SHALL be modulo 2^WIDTH, with no carry-out port.
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 In IDLE, start=1 SHALL latch a, b, ALUctr and shamt (edge E0), load the shift counter with shamt, and move to BUSY.
REQ-016 In BUSY with a non-SLL opcode, the block SHALL register result, zero, illegal and overflow at the next edge and move to DONE.
REQ-017 In BUSY with SLL, each edge SHALL shift the working value left by 1 and decrement the counter while the counter is >0; the block SHALL move to DONE at the edge where the counter is <=1.
REQ-018 SLL latency from E0 to DONE SHALL therefore be max(1, shamt) edges; shamt=0 SHALL return b unchanged.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 start SHALL be ignored in BUSY and DONE; latched operands SHALL NOT change while busy.
REQ-021 result, zero, illegal and overflow SHALL hold their values from the last completion until the next completion.
REQ-022 An unsupported ALUctr SHALL complete with latency 1, result=0, zero=1 and illegal=1; a legal opcode SHALL clear illegal.
REQ-023 done SHALL be asserted only in DONE; busy SHALL be 1 in BUSY and DONE.

Reset
REQ-024 rst_n=0 SHALL immediately force state to IDLE and busy, done, result, zero, illegal, overflow and the shift counter to 0, aborting any operation in flight.
REQ-025 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-026 With ALU_OVERFLOW_EN defined, overflow SHALL be 1 on completion of ADD or SUB when the signed two's-complement result overflows, and 0 for all other opcodes.
REQ-027 Without ALU_OVERFLOW_EN, overflow SHALL be constant 0 and no overflow logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover ADD: a=0x00000005, b=0x00000003, ALUctr=0010 -> done one edge after accept, result=0x00000008, zero=0.
REQ-029 The bench SHALL cover SUB/SLT: a=3, b=3, ALUctr=0110 -> result=0, zero=1; a=0xFFFFFFFF, b=1, ALUctr=0111 -> result=1; ALUctr=0101 -> result=0.
REQ-030 The bench SHALL cover SLL: b=0x00000001, shamt=31 -> done 31 edges after accept, result=0x80000000; shamt=0 -> latency 1, result=0x00000001.
REQ-031 The bench SHALL cover overflow, with ALU_OVERFLOW_EN defined: ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1; without the macro, same stimulus -> overflow=0.
REQ-032 The bench SHALL cover start held high during SLL shamt=10 -> exactly one completion, with new operands accepted only from IDLE.
REQ-033 The bench SHALL cover reset mid-shift: rst_n=0 at cycle 4 of SLL shamt=20 -> busy=0, done=0 and result=0 immediately, with no done pulse afterwards.
